upsample_2x2: RTL

UPSAMPLE_2X2 -- requirements
Module: upsample_2x2

---
 rtl/upsample_2x2.sv | 110 +++++++++++
 1 files changed

// File: rtl/upsample_2x2.sv
// 2x2 nearest-neighbour upsampler: each input row is emitted twice per pixel on
// a first output row (straight from input) and replayed from a line buffer on the second.
module upsample_2x2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_eol
);
  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROW_LEN - 1);

  typedef enum logic { LOAD = 1'b0, REPLAY = 1'b1 } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_col, w_col_nxt, w_col_inc, w_col_w;
  logic                  r_rep, w_rep_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
  logic [DATA_WIDTH-1:0] r_buf [ROW_LEN];
  logic                  w_last, w_in_acc, w_out_acc;

  assign w_last    = (r_col == LAST);
  assign w_col_inc = r_col + CW'(1);
  assign in_ready  = (r_state == LOAD) &&
                     (!r_out_valid || (out_ready && r_rep && !w_last));
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = r_out_valid && out_ready;
  // While a pixel is showing, a new one is only taken alongside the column advance.
  assign w_col_w   = r_out_valid ? w_col_inc : r_col;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_eol   = r_out_valid && r_rep && w_last;

  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_rep_nxt       = r_rep;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    case (r_state)
      LOAD: begin
        if (w_out_acc && !r_rep) begin
          w_rep_nxt = 1'b1;
        end else if (w_out_acc) begin
          w_rep_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt     = REPLAY;
            w_col_nxt       = '0;
            w_out_data_nxt  = r_buf[0];
            w_out_valid_nxt = 1'b1;
          end else begin
            w_col_nxt       = w_col_inc;
            w_out_valid_nxt = w_in_acc;
            if (w_in_acc) w_out_data_nxt = in_data;
          end
        end else if (w_in_acc) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = in_data;
          w_rep_nxt       = 1'b0;
        end
      end
      REPLAY: begin
        if (w_out_acc && !r_rep) begin
          w_rep_nxt = 1'b1;
        end else if (w_out_acc) begin
          w_rep_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt     = LOAD;
            w_col_nxt       = '0;
            w_out_valid_nxt = 1'b0;
          end else begin
            w_col_nxt      = w_col_inc;
            w_out_data_nxt = r_buf[w_col_inc];
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_col       <= '0;
      r_rep       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_rep       <= w_rep_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  // Line buffer is never reset; every entry is rewritten before it is replayed.
  always_ff @(posedge clk) begin
    if (w_in_acc) r_buf[w_col_w] <= in_data;
  end
endmodule
